// File: rtl/qsort_ctrl_if.sv
// Handshake bundle between the quicksort scheduler and its partition partner.
// The master side is the scheduler; the slave side is the loader/partition environment.
interface qsort_ctrl_if #(
  parameter int K = 10
) ();
  localparam int IW = $clog2(K) + 1;

  logic          start;
  logic [IW-1:0] count;
  logic          finish_sort;
  logic [IW-1:0] index;
  logic [IW-1:0] H;
  logic [IW-1:0] No_element;
  logic          start_sort;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, count, finish_sort, index,
    output H, No_element, start_sort, busy, done, err
  );

  modport slave (
    output start, count, finish_sort, index,
    input  H, No_element, start_sort, busy, done, err
  );
endinterface

// File: rtl/qsort_ctrl.sv
// Quicksort scheduler: keeps a LIFO of pending {lo, n} ranges and feeds them one at a
// time to the partition stage until every remaining range holds fewer than two elements.
module qsort_ctrl #(
  parameter int N = 23,
  parameter int M = 8,
  parameter int K = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  qsort_ctrl_if.master bus
);
  localparam int IW = $clog2(K) + 1;
  localparam int AW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] TWO  = IW'(2);
  localparam logic [IW-1:0] KMAX = IW'(K);

  if (K < 2 || N < 1 || M < 0) begin : g_bad_params
    $error("qsort_ctrl: K must be >= 2 and the element format must be non-empty");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_SETUP, S_RUN, S_SPLIT, S_DONE
  } state_t;

  state_t        state_q;
  logic [IW-1:0] sp_q;
  logic [IW-1:0] h_q;
  logic [IW-1:0] n_q;
  logic [IW-1:0] p_q;
  logic          start_sort_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [IW-1:0] stk_lo [K];
  logic [IW-1:0] stk_n  [K];

  logic [IW-1:0] top_d, sp1_d, last_d;
  logic [IW-1:0] lft_n_d, rgt_lo_d, rgt_n_d;
  logic [IW-1:0] big_lo_d, big_n_d, sml_lo_d, sml_n_d;
  logic          bad_p_d, big_ok_d, sml_ok_d;
  logic [IW-1:0] push_d;
  logic          wa_en, wb_en;
  logic [AW-1:0] wa_addr, wb_addr;
  logic [IW-1:0] wa_lo, wa_n, wb_lo, wb_n;

  // Child ranges of the captured pivot; the larger child goes deeper in the stack.
  always_comb begin
    top_d    = sp_q - ONE;
    sp1_d    = sp_q + ONE;
    last_d   = h_q + n_q - ONE;
    lft_n_d  = p_q - h_q;
    rgt_lo_d = p_q + ONE;
    rgt_n_d  = last_d - p_q;
    bad_p_d  = (p_q < h_q) || (p_q > last_d);
    if (lft_n_d >= rgt_n_d) begin
      big_lo_d = h_q;      big_n_d = lft_n_d;
      sml_lo_d = rgt_lo_d; sml_n_d = rgt_n_d;
    end else begin
      big_lo_d = rgt_lo_d; big_n_d = rgt_n_d;
      sml_lo_d = h_q;      sml_n_d = lft_n_d;
    end
    big_ok_d = !bad_p_d && (big_n_d >= TWO);
    sml_ok_d = !bad_p_d && (sml_n_d >= TWO);
    push_d   = IW'(big_ok_d) + IW'(sml_ok_d);

    wa_en   = 1'b0;
    wa_addr = sp_q[AW-1:0];
    wa_lo   = big_lo_d;
    wa_n    = big_n_d;
    wb_en   = 1'b0;
    wb_addr = sp1_d[AW-1:0];
    wb_lo   = sml_lo_d;
    wb_n    = sml_n_d;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.count >= TWO) && (bus.count <= KMAX)) begin
          wa_en   = 1'b1;
          wa_addr = '0;
          wa_lo   = '0;
          wa_n    = bus.count;
        end
      end
      S_SPLIT: begin
        wa_en = big_ok_d;
        wb_en = sml_ok_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wa_en) begin
      stk_lo[wa_addr] <= wa_lo;
      stk_n[wa_addr]  <= wa_n;
    end
    if (wb_en) begin
      stk_lo[wb_addr] <= wb_lo;
      stk_n[wb_addr]  <= wb_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sp_q         <= '0;
      h_q          <= '0;
      n_q          <= '0;
      p_q          <= '0;
      start_sort_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.count > KMAX) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (bus.count <= ONE) begin
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q   <= 1'b0;
              sp_q    <= ONE;
              state_q <= S_POP;
            end
          end
        end
        S_POP: begin
          if (sp_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            h_q     <= stk_lo[top_d[AW-1:0]];
            n_q     <= stk_n[top_d[AW-1:0]];
            sp_q    <= top_d;
            state_q <= S_SETUP;
          end
        end
        // One idle cycle with the new range stable lets the partner re-arm.
        S_SETUP: begin
          start_sort_q <= 1'b1;
          state_q      <= S_RUN;
        end
        S_RUN: begin
          if (bus.finish_sort) begin
            p_q          <= bus.index;
            start_sort_q <= 1'b0;
            state_q      <= S_SPLIT;
          end
        end
        S_SPLIT: begin
          if (bad_p_d) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            sp_q    <= sp_q + push_d;
            state_q <= S_POP;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.H          = h_q;
  assign bus.No_element = n_q;
  assign bus.start_sort = start_sort_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: doc/qsort_ctrl.md
Name: qsort_ctrl

Overview:
- Quicksort scheduler placed directly upstream of the partition stage. Drives that stage's range inputs `H` and `No_element` and its `start_sort` level, then consumes `finish_sort` and the final pivot position `index`.
- Keeps a LIFO stack of pending sub-ranges and issues partitions until every range has fewer than 2 elements.
- Sits between the memory loader, which raises `finish_mem`, and the partition stage, which sorts the G array in place.

Parameters:
- N, 23, integer bits of a fixed-point element (passed through for consistency with the partition stage).
- M, 8, fractional bits of an element.
- K, 10, maximum number of elements in the array.
- IW, $clog2(K)+1, width of every index and count (localparam).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to sort elements 0..count-1; accepted only in IDLE.
- count  input  IW  number of valid elements; sampled with start.
- finish_sort  input  1  partition-complete flag from the partition stage.
- index  input  IW  final pivot position from the partition stage; valid while finish_sort=1.
- H  output  IW  first element of the range being partitioned.
- No_element  output  IW  element count of that range.
- start_sort  output  1  level; held high for a partition, low otherwise.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when sorting ends.
- err  output  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset: all outputs are 0, the stack pointer is 0, and the FSM is in IDLE. Reset is asynchronous and overrides everything, including mid-RUN; start_sort drops immediately.
- Stack storage:
  - K entries of {lo, n}, each field IW bits wide.
  - Pushes and pops are LIFO.
  - In SPLIT the larger child is pushed first and the smaller child second, so the smaller child pops first. Depth therefore never exceeds floor(log2 K)+1.
- FSM states: IDLE, POP, SETUP, RUN, SPLIT, DONE.
- IDLE:
  - start=1 and count>K: set err=1, busy=1, go to DONE.
  - start=1 and count<=1: clear err, set busy=1, go to DONE with nothing pushed.
  - start=1 otherwise: clear err, push {0,count}, set busy=1, go to POP.
  - start is ignored in every state except IDLE.
- POP:
  - Stack empty: go to DONE.
  - Otherwise: pop the top entry, load it into H and No_element, go to SETUP.
- SETUP:
  - Lasts exactly one cycle with start_sort=0 and H/No_element stable, so the partition stage reinitialises its scan indices and clears finish_sort.
  - Next state is RUN.
- RUN:
  - start_sort=1.
  - finish_sort is sampled only in this state; it is ignored in all others.
  - On finish_sort=1: capture p=index, drop start_sort at the same edge, go to SPLIT.
  - No timeout.
- SPLIT (one cycle, start_sort=0):
  - If p<H or p>H+No_element-1: set err=1, go to DONE.
  - Otherwise the children are left {H, p-H} and right {p+1, H+No_element-1-p}.
  - Only children with n>=2 are pushed; 0, 1 or 2 pushes happen in this cycle.
  - When the two child sizes are equal, left is pushed first.
  - All arithmetic is unsigned IW-bit; the range check rules out underflow.
  - Next state is POP.
- DONE: done=1 for exactly this cycle, busy=0 at the following edge, then IDLE.
- Latency:
  - For count<=1, done is high in the cycle after start is sampled.
  - Each partition costs the partition-stage time plus 3 controller cycles: SPLIT, POP and SETUP.
- Stable outputs: H and No_element hold their last values in IDLE and DONE.

Test Plan:
- Assert rst_n low while in RUN -> start_sort, busy, done, err and H are 0 immediately; a new start afterwards sorts correctly.
- start with count=1, then count=0 -> done pulses in the cycle after start; start_sort is never high; err=0.
- count=2 with a stub partner returning index=1 after 3 cycles -> sequence H=0/No_element=2, one RUN, SPLIT pushes nothing, then done; exactly one start_sort high window.
- Integrated with the partition stage and loader, K=10, a={5,3,8,1,9,2,7,4,6,0} -> G ends ascending 0..9; done pulses once; stack depth never exceeds 4; start_sort is low for at least 1 cycle between partitions.
- Stub returns index=7 for H=0, No_element=5 -> err=1, done the cycle after SPLIT, no further start_sort.
- count=11 -> err=1, done next cycle. A start pulse during RUN is ignored: H is unchanged and busy stays 1.
